// File: rtl/led_breath_sched.sv
// Four-channel LED breathing sequencer: debounced key steps IDLE -> RUN <-> PAUSE,
// each channel fades in then out via PWM before handing over to the next one.
module led_breath_sched #(
   parameter int CNT_1US_MAX = 49,
   parameter int CNT_1MS_MAX = 999,
   parameter int CNT_1S_MAX  = 999,
   parameter int DEB_MAX     = 999_999
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic [3:0] led_out,
   output logic [1:0] cur_ch,
   output logic [1:0] run_st
);

   localparam int US_W  = (CNT_1US_MAX > 0) ? $clog2(CNT_1US_MAX + 1) : 1;
   localparam int MS_W  = (CNT_1MS_MAX > 0) ? $clog2(CNT_1MS_MAX + 1) : 1;
   localparam int S_W   = (CNT_1S_MAX  > 0) ? $clog2(CNT_1S_MAX  + 1) : 1;
   localparam int DEB_W = $clog2(DEB_MAX + 2);
   localparam int CMP_W = (MS_W > S_W) ? MS_W : S_W;

   localparam logic [US_W-1:0]  US_LAST  = US_W'(CNT_1US_MAX);
   localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CNT_1MS_MAX);
   localparam logic [S_W-1:0]   S_LAST   = S_W'(CNT_1S_MAX);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX);
   localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEB_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              key_s1, key_s2;
   logic [DEB_W-1:0]  deb_cnt;
   logic              key_pulse;
   logic [US_W-1:0]   cnt_us;
   logic [MS_W-1:0]   cnt_ms;
   logic [S_W-1:0]    cnt_s;
   logic              dir;
   logic              us_tick, ms_wrap;
   logic [S_W-1:0]    level;
   logic              pwm_on;
   logic [3:0]        led_next;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_in;
         key_s2 <= key_s1;
      end
   end

   // Counter parks one past DEB_MAX so a long hold yields a single pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         deb_cnt <= '0;
      else if (key_s2)
         deb_cnt <= '0;
      else if (deb_cnt != DEB_SAT)
         deb_cnt <= deb_cnt + DEB_W'(1);
   end

   assign key_pulse = (deb_cnt == DEB_LAST);

   assign us_tick = (cnt_us == US_LAST);
   assign ms_wrap = us_tick && (cnt_ms == MS_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_us <= '0;
         cnt_ms <= '0;
      end else begin
         cnt_us <= us_tick ? '0 : cnt_us + US_W'(1);
         if (us_tick)
            cnt_ms <= (cnt_ms == MS_LAST) ? '0 : cnt_ms + MS_W'(1);
      end
   end

   // Advance is keyed on the current state, so a pause landing on the
   // end-of-fade-out edge still completes the channel hand-over.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_s  <= '0;
         dir    <= 1'b0;
         cur_ch <= '0;
      end else if (state_q == IDLE) begin
         cnt_s  <= '0;
         dir    <= 1'b0;
         cur_ch <= '0;
      end else if (state_q == RUN && ms_wrap) begin
         if (cnt_s == S_LAST) begin
            cnt_s <= '0;
            dir   <= ~dir;
            if (dir)
               cur_ch <= cur_ch + 2'd1;
         end else begin
            cnt_s <= cnt_s + S_W'(1);
         end
      end
   end

   assign level  = dir ? (S_LAST - cnt_s) : cnt_s;
   assign pwm_on = (CMP_W'(cnt_ms) < CMP_W'(level));

   always_comb begin
      led_next = '1;
      if (state_q != IDLE && pwm_on)
         led_next[cur_ch] = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         led_out <= '1;
      else
         led_out <= led_next;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (key_pulse) state_d = RUN;
         RUN:     if (key_pulse) state_d = PAUSE;
         PAUSE:   if (key_pulse) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   assign run_st = state_q;

endmodule
